// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // NORMAL: processor has priority. FORCE: one-cycle stall so a game write lands.
  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// searching upward and wrapping. Returns a one-hot grant and its index.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan N candidates starting at ptr_i; the first hit wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid_o && req_i[(int'(ptr_i) + k) % N]) begin
        valid_o                         = 1'b1;
        gnt_o[(int'(ptr_i) + k) % N]    = 1'b1;
        idx_o                           = IDX_W'((int'(ptr_i) + k) % N);
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the regfile's single write port between processor writeback
// and N_GAME game requesters. The processor normally wins; an age counter
// forces a one-cycle processor stall so game requesters cannot starve.
import regfile_write_arbiter_pkg::*;

module regfile_write_arbiter #(
  parameter int N_GAME   = 2,
  parameter int MAX_WAIT = 4,
  parameter int AGE_W    = 3
) (
  input  logic                         clock,
  input  logic                         ctrl_reset,
  input  logic                         cpu_we,
  input  logic [REG_ADDR_W-1:0]        cpu_wreg,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic                         cpu_stall,
  input  logic [N_GAME-1:0]            game_req,
  input  logic [REG_ADDR_W*N_GAME-1:0] game_wreg,
  input  logic [DATA_W*N_GAME-1:0]     game_wdata,
  output logic [N_GAME-1:0]            game_gnt,
  output logic                         ctrl_writeEnable,
  output logic [REG_ADDR_W-1:0]        ctrl_writeReg,
  output logic [DATA_W-1:0]            data_writeReg
);

  localparam int IDX_W = (N_GAME > 1) ? $clog2(N_GAME) : 1;

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [AGE_W-1:0]       age_q, age_d;
  logic                   we_q, we_d;
  logic [REG_ADDR_W-1:0]  wreg_q, wreg_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;

  logic [N_GAME-1:0]      pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   game_win;
  logic                   any_req;

  rr_pick #(
    .N     (N_GAME),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (game_req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign any_req = |game_req;

  // Choose the accepted source, drive grant/stall, and compute all next state.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    age_d     = age_q;
    we_d      = 1'b0;
    wreg_d    = wreg_q;
    wdata_d   = wdata_q;
    game_gnt  = '0;
    cpu_stall = 1'b0;
    game_win  = 1'b0;

    if (!ctrl_reset) begin
      // Reset cycle: nothing is granted or stalled; the register block clears state.
      game_win = 1'b0;
    end else begin
      if (state_q == FORCE) begin
        cpu_stall = 1'b1;
        game_win  = pick_valid;
      end else if (cpu_we) begin
        we_d    = (cpu_wreg != REG_ZERO);
        wreg_d  = cpu_wreg;
        wdata_d = cpu_wdata;
      end else begin
        game_win = pick_valid;
      end

      if (game_win) begin
        game_gnt = pick_gnt;
        we_d     = (game_wreg[int'(pick_idx)*REG_ADDR_W +: REG_ADDR_W] != REG_ZERO);
        wreg_d   = game_wreg[int'(pick_idx)*REG_ADDR_W +: REG_ADDR_W];
        wdata_d  = game_wdata[int'(pick_idx)*DATA_W +: DATA_W];
        ptr_d    = (pick_idx == IDX_W'(N_GAME - 1)) ? {IDX_W{1'b0}} : pick_idx + {{(IDX_W-1){1'b0}}, 1'b1};
        age_d    = '0;
      end else if (state_q == FORCE) begin
        // Forced slot with every request withdrawn: just clear the age.
        age_d = '0;
      end else if (any_req) begin
        age_d = (age_q == {AGE_W{1'b1}}) ? age_q : age_q + {{(AGE_W-1){1'b0}}, 1'b1};
      end else begin
        age_d = age_q;
      end

      if (state_q == FORCE) begin
        state_d = NORMAL;
      end else if ((age_d == AGE_W'(MAX_WAIT)) && any_req) begin
        state_d = FORCE;
      end else begin
        state_d = NORMAL;
      end
    end
  end

  // State and registered regfile write port, with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      state_q <= NORMAL;
      ptr_q   <= '0;
      age_q   <= '0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      age_q   <= age_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: a behavioural model checked
// every cycle plus directed vectors with hand-computed expectations.
module tb_regfile_write_arbiter;

  localparam int N  = 2;
  localparam int MW = 4;
  localparam int AW = 3;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        cpu_we;
  logic [4:0]  cpu_wreg;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [N-1:0]    game_req;
  logic [5*N-1:0]  game_wreg;
  logic [32*N-1:0] game_wdata;
  logic [N-1:0]    game_gnt;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  int checks   = 0;
  int failures = 0;

  // Model state (plain integers, rules applied directly)
  bit          m_valid = 1'b0;
  bit          m_force;
  int          m_ptr;
  int          m_age;
  bit          m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  regfile_write_arbiter #(.N_GAME(N), .MAX_WAIT(MW), .AGE_W(AW)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .cpu_we           (cpu_we),
    .cpu_wreg         (cpu_wreg),
    .cpu_wdata        (cpu_wdata),
    .cpu_stall        (cpu_stall),
    .game_req         (game_req),
    .game_wreg        (game_wreg),
    .game_wdata       (game_wdata),
    .game_gnt         (game_gnt),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model of one cycle: which source is accepted and what the port shows.
  task automatic model_cycle(output logic [N-1:0] g, output bit st, output bit acc,
                             output logic [4:0] r, output logic [31:0] d, output int win);
    g = '0; st = 1'b0; acc = 1'b0; r = '0; d = '0; win = -1;
    if (ctrl_reset) begin
      st = m_force;
      if (m_force || !cpu_we) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (win < 0 && game_req[c]) win = c;
        end
        if (win >= 0) begin
          g[win] = 1'b1;
          acc = 1'b1;
          r = game_wreg[5*win +: 5];
          d = game_wdata[32*win +: 32];
        end
      end else begin
        acc = 1'b1;
        r = cpu_wreg;
        d = cpu_wdata;
      end
    end
  endtask

  // Compare process: check at negedge, then advance the model for the coming edge.
  initial begin
    logic [N-1:0] eg;
    bit est, eacc;
    logic [4:0] er;
    logic [31:0] ed;
    int win;
    forever begin
      @(negedge clock);
      model_cycle(eg, est, eacc, er, ed, win);
      if (m_valid) begin
        chk("m_gnt",   32'(game_gnt), 32'(eg));
        chk("m_stall", 32'(cpu_stall), 32'(est));
        chk("m_we",    32'(ctrl_writeEnable), 32'(m_we));
        chk("m_wreg",  32'(ctrl_writeReg), 32'(m_reg));
        chk("m_wdata", data_writeReg, m_data);
      end
      if (!ctrl_reset) begin
        m_valid = 1'b1; m_force = 1'b0; m_ptr = 0; m_age = 0;
        m_we = 1'b0; m_reg = '0; m_data = '0;
      end else if (m_valid) begin
        bit was_force;
        was_force = m_force;
        if (eacc) begin
          m_we = (er != 5'd0); m_reg = er; m_data = ed;
        end else begin
          m_we = 1'b0;
        end
        if (win >= 0) begin
          m_age = 0; m_ptr = (win + 1) % N;
        end else if (was_force) begin
          m_age = 0;
        end else if (game_req != '0) begin
          m_age = (m_age + 1 > (1 << AW) - 1) ? m_age : m_age + 1;
        end
        m_force = !was_force && (m_age == MW) && (game_req != '0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    ctrl_reset = 1'b0; cpu_we = 1'b0; cpu_wreg = '0; cpu_wdata = '0;
    game_req = '0; game_wreg = '0; game_wdata = '0;

    // Reset then idle
    tick();
    #2;
    chk("rst_we", 32'(ctrl_writeEnable), 32'd0);
    chk("rst_wreg", 32'(ctrl_writeReg), 32'd0);
    chk("rst_wdata", data_writeReg, 32'd0);
    chk("rst_gnt", 32'(game_gnt), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    tick();
    ctrl_reset = 1'b1;

    // CPU only
    cpu_we = 1'b1; cpu_wreg = 5'd5; cpu_wdata = 32'hDEADBEEF;
    #2;
    chk("cpu_stall", 32'(cpu_stall), 32'd0);
    chk("cpu_gnt", 32'(game_gnt), 32'd0);
    tick();
    cpu_we = 1'b0;
    #2;
    chk("cpu_we_out", 32'(ctrl_writeEnable), 32'd1);
    chk("cpu_wreg_out", 32'(ctrl_writeReg), 32'd5);
    chk("cpu_wdata_out", data_writeReg, 32'hDEADBEEF);

    // Round-robin 01,10,01
    game_wreg = {5'd4, 5'd3}; game_wdata = {32'd200, 32'd100}; game_req = 2'b11;
    #2; chk("rr_gnt0", 32'(game_gnt), 32'd1);
    tick();
    #2; chk("rr_gnt1", 32'(game_gnt), 32'd2);
    chk("rr_wreg0", 32'(ctrl_writeReg), 32'd3);
    chk("rr_wdata0", data_writeReg, 32'd100);
    tick();
    #2; chk("rr_gnt2", 32'(game_gnt), 32'd1);
    chk("rr_wreg1", 32'(ctrl_writeReg), 32'd4);
    chk("rr_wdata1", data_writeReg, 32'd200);
    tick();
    game_req = '0;
    #2; chk("rr_we2", 32'(ctrl_writeEnable), 32'd1);
    chk("rr_wreg2", 32'(ctrl_writeReg), 32'd3);
    tick();
    #2; chk("idle_we", 32'(ctrl_writeEnable), 32'd0);
    chk("idle_hold", 32'(ctrl_writeReg), 32'd3);

    // Starvation: CPU writes continuously, requester 1 waits
    cpu_we = 1'b1; cpu_wreg = 5'd9; cpu_wdata = 32'h11;
    game_wreg = {5'd25, 5'd3}; game_wdata = {32'd7, 32'd100}; game_req = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("starve_stall", 32'(cpu_stall), 32'd0);
      chk("starve_gnt", 32'(game_gnt), 32'd0);
      tick();
    end
    #2;
    chk("force_stall", 32'(cpu_stall), 32'd1);
    chk("force_gnt", 32'(game_gnt), 32'd2);
    tick();
    game_req = '0;
    #2;
    chk("force_we", 32'(ctrl_writeEnable), 32'd1);
    chk("force_wreg", 32'(ctrl_writeReg), 32'd25);
    chk("force_wdata", data_writeReg, 32'd7);
    chk("after_stall", 32'(cpu_stall), 32'd0);
    tick();
    cpu_we = 1'b0;
    tick();

    // Register 0 guard
    game_wreg = {5'd25, 5'd0}; game_wdata = {32'd7, 32'h55}; game_req = 2'b01;
    #2; chk("r0_gnt", 32'(game_gnt), 32'd1);
    tick();
    game_req = '0;
    #2;
    chk("r0_we", 32'(ctrl_writeEnable), 32'd0);
    chk("r0_wreg", 32'(ctrl_writeReg), 32'd0);
    chk("r0_wdata", data_writeReg, 32'h55);
    tick();

    // Reset while in FORCE
    cpu_we = 1'b1; cpu_wreg = 5'd9; game_wreg = {5'd25, 5'd12}; game_req = 2'b01;
    for (int i = 0; i < 4; i++) tick();
    ctrl_reset = 1'b0;
    #2;
    chk("rf_stall", 32'(cpu_stall), 32'd0);
    chk("rf_gnt", 32'(game_gnt), 32'd0);
    tick();
    ctrl_reset = 1'b1;
    #2;
    chk("rf_we", 32'(ctrl_writeEnable), 32'd0);
    chk("rf_wreg", 32'(ctrl_writeReg), 32'd0);
    chk("rf_wdata", data_writeReg, 32'd0);
    for (int i = 0; i < 4; i++) begin
      #2 chk("rf_normal_stall", 32'(cpu_stall), 32'd0);
      tick();
    end
    // Forced slot with the request withdrawn
    game_req = '0;
    #2;
    chk("drop_stall", 32'(cpu_stall), 32'd1);
    chk("drop_gnt", 32'(game_gnt), 32'd0);
    tick();
    #2; chk("drop_we", 32'(ctrl_writeEnable), 32'd0);

    // Withdrawn request: age holds while nothing is pending
    game_req = 2'b01;
    tick(); tick();
    game_req = '0;
    tick(); tick(); tick();
    game_req = 2'b01;
    tick(); tick();
    #2;
    chk("wd_stall", 32'(cpu_stall), 32'd1);
    chk("wd_gnt", 32'(game_gnt), 32'd1);
    tick();
    game_req = '0; cpu_we = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
